// File: rtl/prim_gate_pkg.sv
// Shared types for the pipelined gate primitive: operation encoding and counter width.
package prim_gate_pkg;

  localparam int unsigned BEAT_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_NOT = 2'd1,
    OP_BUF = 2'd2,
    OP_OR  = 2'd3
  } op_e;

endpackage

// File: rtl/prim_gate_stage.sv
// One elastic register stage: holds a single result word plus its valid bit.
module prim_gate_stage
  import prim_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Refill whenever the slot is empty or its beat leaves this cycle.
  assign up_ready = ~valid | dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/prim_gate_pipe.sv
// Selectable AND/NOT/BUF/OR across NIN words followed by DEPTH elastic stages.
// Optional supply monitoring is enabled by defining PRIM_GATE_PIPE_PWR_CHECK_EN.
module prim_gate_pipe
  import prim_gate_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NIN   = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  VDD,
  input  logic                  VSS,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [NIN*WIDTH-1:0]  in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam int unsigned DW = NIN * WIDTH;

  function automatic logic [WIDTH-1:0] gate_op(input op_e op, input logic [DW-1:0] d);
    logic [WIDTH-1:0] all_and;
    logic [WIDTH-1:0] all_or;
    logic [WIDTH-1:0] res;
    all_and = '1;
    all_or  = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      all_and = all_and & d[k*WIDTH +: WIDTH];
      all_or  = all_or  | d[k*WIDTH +: WIDTH];
    end
    case (op)
      OP_AND:  res = all_and;
      OP_NOT:  res = ~d[WIDTH-1:0];
      OP_BUF:  res = d[WIDTH-1:0];
      default: res = all_or;
    endcase
    return res;
  endfunction

  logic pwr_ok;

`ifdef PRIM_GATE_PIPE_PWR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwr_ok <= 1'b1;
    else        pwr_ok <= VDD & ~VSS;
  end
`else
  logic unused_pwr;
  assign pwr_ok     = 1'b1;
  assign unused_pwr = VDD ^ VSS;
`endif

  logic [DEPTH-1:0] stg_vld;
  logic [DEPTH-1:0] stg_up_rdy;
  logic [DEPTH-1:0] stg_dn_rdy;
  logic [WIDTH-1:0] stg_dat [DEPTH];
  logic [WIDTH-1:0] op_res;
  logic             out_rdy_m;
  logic             accept;
  logic             unused_rdy;

  assign op_res    = gate_op(op_e'(in_op), in_data);
  assign out_rdy_m = out_ready & pwr_ok;
  assign in_ready  = stg_up_rdy[0] & rst_n & pwr_ok;
  assign accept    = in_valid & in_ready;

  // Downstream ready of stage i, flattened from the stage valid registers so
  // no combinational signal depends on another bit of itself.
  always_comb begin : dn_ready_chain
    logic r;
    stg_dn_rdy = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      r = out_rdy_m;
      for (int unsigned j = i + 1; j < DEPTH; j++) r = r | ~stg_vld[j];
      stg_dn_rdy[i] = r;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    if (i == 0) begin : g_head
      assign up_v = accept;
      assign up_d = op_res;
    end else begin : g_body
      assign up_v = stg_vld[i-1];
      assign up_d = stg_dat[i-1];
    end
    prim_gate_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (~pwr_ok),
      .up_valid (up_v),
      .up_data  (up_d),
      .up_ready (stg_up_rdy[i]),
      .dn_ready (stg_dn_rdy[i]),
      .valid    (stg_vld[i]),
      .data     (stg_dat[i])
    );
  end

  assign unused_rdy = ^stg_up_rdy;
  assign out_valid  = stg_vld[DEPTH-1] & pwr_ok;
  assign out_data   = stg_dat[DEPTH-1];
  assign busy       = |stg_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
  end

endmodule

// File: tb/tb_prim_gate_pipe.sv
// Directed and long-stream checks for prim_gate_pipe at WIDTH=4, NIN=3, DEPTH=2.
module tb_prim_gate_pipe;
  import prim_gate_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NIN   = 3;
  localparam int unsigned DEPTH = 2;
  localparam int NBEATS = 70000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 VDD = 1'b1;
  logic                 VSS = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [1:0]           in_op = 2'd0;
  logic [NIN*WIDTH-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     out_data;
  logic                 busy;
  logic [15:0]          beat_cnt;

  prim_gate_pipe #(.WIDTH(WIDTH), .NIN(NIN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .VDD(VDD), .VSS(VSS),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] got_q[$];
  logic [WIDTH-1:0] want_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] d);
    in_valid = v;
    in_op    = op;
    in_data  = d;
  endtask

  function automatic logic [3:0] model(input logic [1:0] op, input logic [11:0] d);
    case (op)
      2'd0:    return d[3:0] & d[7:4] & d[11:8];
      2'd1:    return ~d[3:0];
      2'd2:    return d[3:0];
      default: return d[3:0] | d[7:4] | d[11:8];
    endcase
  endfunction

  // Record every delivered word; outputs are stable here until the next rising edge.
  always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);

  initial begin
    int k, guard, sent, cyc, bad;
    logic [15:0] bc;

    #12;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_beat_cnt",  32'(beat_cnt),  32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // AND of F,E,6 -> 6, visible one edge after acceptance, handed over on the next
    out_ready = 1'b1;
    drive(1'b1, OP_AND, 12'h6EF);
    tick();
    drive(1'b0, OP_AND, 12'h000);
    #1;
    check("and_lat_valid0", 32'(out_valid), 32'd0);
    check("and_busy",       32'(busy),      32'd1);
    tick(); #1;
    check("and_valid", 32'(out_valid), 32'd1);
    check("and_data",  32'(out_data),  32'h6);
    tick(); #1;
    check("and_done_valid", 32'(out_valid), 32'd0);
    check("and_beat_cnt",   32'(beat_cnt),  32'd1);

    // back-to-back NOT 5, BUF 9, OR 1|2|8
    drive(1'b1, OP_NOT, 12'h005);
    tick();
    drive(1'b1, OP_BUF, 12'h009);
    #1; check("b2b_v0", 32'(out_valid), 32'd0);
    tick();
    drive(1'b1, OP_OR, 12'h821);
    #1; check("b2b_not", 32'(out_data), 32'hA);
    check("b2b_not_v", 32'(out_valid), 32'd1);
    tick();
    drive(1'b0, OP_AND, 12'h000);
    #1; check("b2b_buf", 32'(out_data), 32'h9);
    tick(); #1;
    check("b2b_or", 32'(out_data), 32'hB);
    check("b2b_or_v", 32'(out_valid), 32'd1);
    tick(); #1;
    check("b2b_end_v", 32'(out_valid), 32'd0);
    check("b2b_cnt",   32'(beat_cnt),  32'd4);

    // stall: two beats fill the pipe, third is refused, output held
    got_q.delete();
    out_ready = 1'b0;
    drive(1'b1, OP_BUF, 12'h001);
    #1; check("bp_rdy1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, OP_BUF, 12'h002);
    #1; check("bp_rdy2", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, OP_BUF, 12'h003);
    repeat (3) begin
      #1;
      check("bp_full_rdy",  32'(in_ready),  32'd0);
      check("bp_hold_v",    32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data),  32'h1);
      tick();
    end
    out_ready = 1'b1;
    k = 2; guard = 0;
    while (k < 4 && guard < 20) begin
      drive(1'b1, OP_BUF, 12'(k + 1));
      #1;
      if (in_ready) k++;
      tick();
      guard++;
    end
    drive(1'b0, OP_AND, 12'h000);
    check("bp_accepted", 32'(k), 32'd4);
    guard = 0;
    while (got_q.size() < 4 && guard < 10) begin tick(); guard++; end
    check("bp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("bp_order", 32'(got_q[i]), 32'(i + 1));
    check("bp_cnt", 32'(beat_cnt), 32'd8);

    // long stream with light back-pressure; counter must wrap
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    got_q.delete(); want_q.delete();
    sent = 0; cyc = 0;
    while (sent < NBEATS && cyc < 90000) begin
      in_valid  = 1'b1;
      in_op     = 2'($urandom);
      in_data   = 12'($urandom);
      out_ready = ($urandom_range(15) != 0);
      #1;
      if (in_ready) begin
        want_q.push_back(model(in_op, in_data));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    check("rnd_sent", 32'(sent), 32'(NBEATS));
    check("rnd_count", 32'(got_q.size()), 32'(want_q.size()));
    bad = 0;
    for (int i = 0; i < got_q.size() && i < want_q.size() && bad < 8; i++) begin
      if (got_q[i] !== want_q[i]) bad++;
      check("rnd_data", 32'(got_q[i]), 32'(want_q[i]));
    end
    check("rnd_wrap_cnt", 32'(beat_cnt), 32'd4464);
    check("rnd_busy", 32'(busy), 32'd0);

    // asynchronous reset with two beats in flight
    out_ready = 1'b0;
    drive(1'b1, OP_BUF, 12'h005);
    tick();
    drive(1'b1, OP_BUF, 12'h006);
    tick();
    drive(1'b0, OP_AND, 12'h000);
    #1; check("fl_busy", 32'(busy), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_busy",  32'(busy),      32'd0);
    check("ar_cnt",   32'(beat_cnt),  32'd0);
    check("ar_rdy",   32'(in_ready),  32'd0);
    check("ar_data",  32'(out_data),  32'd0);
    #1; rst_n = 1'b1;
    tick();
    got_q.delete();
    out_ready = 1'b1;
    drive(1'b1, OP_OR, 12'h043);
    tick();
    drive(1'b0, OP_AND, 12'h000);
    guard = 0;
    while (!out_valid && guard < 5) begin tick(); guard++; end
    #1;
    check("post_rst_v",    32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data),  32'h7);
    tick(); #1;
    check("post_rst_cnt", 32'(beat_cnt), 32'd1);

`ifdef PRIM_GATE_PIPE_PWR_CHECK_EN
    // supply glitch mid-stream: pipe refuses, hides and flushes, counter frozen
    drive(1'b1, OP_BUF, 12'h00C);
    tick(); tick();
    VSS = 1'b1;
    tick(); #1;
    bc = beat_cnt;
    check("pwr_rdy",   32'(in_ready),  32'd0);
    check("pwr_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    check("pwr_flush", 32'(busy),     32'd0);
    check("pwr_cnt",   32'(beat_cnt), 32'(bc));
    tick();
    VSS = 1'b0;
    #1; check("pwr_still_off", 32'(in_ready), 32'd0);
    tick(); #1;
    check("pwr_back", 32'(in_ready), 32'd1);
    drive(1'b0, OP_AND, 12'h000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
